id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / RAW hazard detection, WB bypass and stall counter.
// Define ID_EX_FWD_EN to enable EX/MEM forwarding; without it, RAW hazards on EX/MEM producers stall.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_op1,
    input  logic [31:0] id_op2,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_imm,
    input  logic        id_isWB,
    input  logic        id_memRead,
    input  logic        id_memWrite,
    input  logic        id_aluSrc,
    input  logic        id_regDst,
    input  logic        id_useRt,
    input  logic [3:0]  id_aluOp,
    input  logic        flush,
    input  logic        mem_isWB,
    input  logic [4:0]  mem_write_reg,
    input  logic [31:0] mem_result,
    input  logic        wb_isWB,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    output logic        stall,
    output logic [31:0] ex_op1,
    output logic [31:0] ex_op2,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_write_reg,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic        ex_isWB,
    output logic        ex_memRead,
    output logic        ex_memWrite,
    output logic        ex_aluSrc,
    output logic [3:0]  ex_aluOp,
    output logic [15:0] stall_cnt
);

    // True when a producer writing wr (nonzero) feeds a source the ID instruction actually reads.
    function automatic logic src_hit(input logic vld, input logic [4:0] wr,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic use_rt);
        return vld && (wr != 5'd0) && ((wr == rs) || (use_rt && (wr == rt)));
    endfunction

    function automatic logic [31:0] sel_op(input logic [4:0] idx, input logic [31:0] rf,
                                           input logic m_vld, input logic [4:0] m_reg,
                                           input logic [31:0] m_dat,
                                           input logic w_vld, input logic [4:0] w_reg,
                                           input logic [31:0] w_dat);
        logic [31:0] r;
        r = rf;
        if (w_vld && (w_reg == idx)) r = w_dat;
        if (m_vld && (m_reg == idx)) r = m_dat;
        if (idx == 5'd0) r = 32'd0;
        return r;
    endfunction

    logic        load_use;
    logic        raw_hazard;
    logic        bubble;
    logic        fwd_vld;
    logic [31:0] op1_sel;
    logic [31:0] op2_sel;
    logic [4:0]  wr_sel;

    assign load_use = src_hit(ex_memRead, ex_write_reg, id_rs, id_rt, id_useRt);

`ifdef ID_EX_FWD_EN
    assign raw_hazard = 1'b0;
    assign fwd_vld    = mem_isWB;
`else
    logic unused_mem_result;
    assign unused_mem_result = ^mem_result;
    assign raw_hazard = src_hit(ex_isWB, ex_write_reg, id_rs, id_rt, id_useRt) ||
                        src_hit(mem_isWB, mem_write_reg, id_rs, id_rt, id_useRt);
    assign fwd_vld    = 1'b0;
`endif

    // Flush squashes the ID instruction, so it never counts as a stall.
    assign stall  = !rst && !flush && (load_use || raw_hazard);
    assign bubble = stall || flush;

    assign op1_sel = sel_op(id_rs, id_op1, fwd_vld, mem_write_reg, mem_result,
                            wb_isWB, wb_write_reg, wb_write_data);
    assign op2_sel = sel_op(id_rt, id_op2, fwd_vld, mem_write_reg, mem_result,
                            wb_isWB, wb_write_reg, wb_write_data);
    assign wr_sel  = id_regDst ? id_rd : id_rt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_op1       <= 32'd0;
            ex_op2       <= 32'd0;
            ex_imm       <= 32'd0;
            ex_write_reg <= 5'd0;
            ex_rs        <= 5'd0;
            ex_rt        <= 5'd0;
            ex_isWB      <= 1'b0;
            ex_memRead   <= 1'b0;
            ex_memWrite  <= 1'b0;
            ex_aluSrc    <= 1'b0;
            ex_aluOp     <= 4'd0;
        end else begin
            ex_op1       <= op1_sel;
            ex_op2       <= op2_sel;
            ex_imm       <= id_imm;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_aluSrc    <= id_aluSrc;
            ex_write_reg <= bubble ? 5'd0 : wr_sel;
            ex_isWB      <= bubble ? 1'b0 : id_isWB;
            ex_memRead   <= bubble ? 1'b0 : id_memRead;
            ex_memWrite  <= bubble ? 1'b0 : id_memWrite;
            ex_aluOp     <= bubble ? 4'd0 : id_aluOp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= 16'd0;
        else if (stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule
